// File: rtl/trig_seq_pkg.sv
// Shared types and helpers for the camera trigger sequencer.
// The optional overrun counter is enabled by defining TRIG_SEQ_OVERRUN_EN.
package trig_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        ACTIVE,
        HOLDOFF
    } trig_seq_state_e;

    localparam int OVERRUN_W = 8;

    // A programmed width of zero still produces a one-cycle pulse.
    function automatic logic [31:0] max1(input logic [31:0] width);
        return (width == 32'd0) ? 32'd1 : width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts one position after last_id and wraps modulo NUM_SRC.
module rr_arbiter #(
    parameter int NUM_SRC = 3
) (
    input  logic [NUM_SRC-1:0]         req,
    input  logic [$clog2(NUM_SRC)-1:0] last_id,
    output logic [NUM_SRC-1:0]         gnt_onehot,
    output logic [$clog2(NUM_SRC)-1:0] gnt_id,
    output logic                       gnt_any
);

    localparam int ID_W = $clog2(NUM_SRC);

    logic [2*NUM_SRC-1:0] w_req2;
    logic [NUM_SRC-1:0]   w_rot;
    logic [ID_W-1:0]      w_start;
    int                   w_j;
    int                   w_sum;

    // Rotate the request vector so the preferred source sits at bit 0,
    // then map the lowest set bit back to its absolute index.
    always_comb begin
        w_req2     = {req, req};
        w_start    = (int'(last_id) == NUM_SRC - 1) ? '0 : last_id + ID_W'(1);
        w_rot      = NUM_SRC'(w_req2 >> w_start);
        w_j        = 0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_j = i;
            end
        end
        w_sum      = int'(w_start) + w_j;
        gnt_any    = |req;
        gnt_id     = '0;
        gnt_onehot = '0;
        if (gnt_any) begin
            gnt_id     = ID_W'((w_sum >= NUM_SRC) ? (w_sum - NUM_SRC) : w_sum);
            gnt_onehot = NUM_SRC'(1) << gnt_id;
        end
    end

endmodule

// File: rtl/trigger_sequencer.sv
// Camera trigger sequencer: edge capture, round-robin grant, delay/pulse/holdoff timing.
// Define TRIG_SEQ_OVERRUN_EN to add the saturating overrun_cnt output.
module trigger_sequencer
    import trig_seq_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [NUM_SRC-1:0]         src_req,
    input  logic [NUM_SRC-1:0]         src_mask,
    input  logic [CNT_W-1:0]           delay_cycles,
    input  logic [CNT_W-1:0]           width_cycles,
    input  logic [CNT_W-1:0]           holdoff_cycles,
    output logic                       trig_out,
    output logic                       busy,
    output logic                       grant_valid,
    output logic [$clog2(NUM_SRC)-1:0] grant_id
`ifdef TRIG_SEQ_OVERRUN_EN
    ,
    output logic [OVERRUN_W-1:0]       overrun_cnt
`endif
);

    localparam int ID_W = $clog2(NUM_SRC);

    trig_seq_state_e     r_state;
    logic [NUM_SRC-1:0]  r_src_req_d1;
    logic [NUM_SRC-1:0]  r_pending;
    logic [ID_W-1:0]     r_last_id;
    logic [ID_W-1:0]     r_grant_id;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_width_m1;
    logic [CNT_W-1:0]    r_holdoff;
    logic                r_trig;
    logic                r_busy;
    logic                r_grant_valid;

    logic [NUM_SRC-1:0]  w_edge;
    logic [NUM_SRC-1:0]  w_clear;
    logic [NUM_SRC-1:0]  w_gnt_onehot;
    logic [ID_W-1:0]     w_gnt_id;
    logic                w_gnt_any;
    logic                w_grant;
    logic [CNT_W-1:0]    w_width_m1;

    assign w_edge     = src_req & ~r_src_req_d1 & src_mask & {NUM_SRC{enable}};
    assign w_grant    = (r_state == IDLE) && enable && w_gnt_any;
    assign w_clear    = w_grant ? w_gnt_onehot : '0;
    assign w_width_m1 = CNT_W'(max1(32'(width_cycles)) - 32'd1);

    rr_arbiter #(
        .NUM_SRC    (NUM_SRC)
    ) u_arbiter (
        .req        (r_pending),
        .last_id    (r_last_id),
        .gnt_onehot (w_gnt_onehot),
        .gnt_id     (w_gnt_id),
        .gnt_any    (w_gnt_any)
    );

    // A new edge on the same cycle as the grant re-arms the pending bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_req_d1 <= '0;
            r_pending    <= '0;
        end else begin
            r_src_req_d1 <= src_req;
            if (!enable) begin
                r_pending <= '0;
            end else begin
                r_pending <= (r_pending & ~w_clear) | w_edge;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_last_id     <= ID_W'(NUM_SRC - 1);
            r_grant_id    <= '0;
            r_cnt         <= '0;
            r_width_m1    <= '0;
            r_holdoff     <= '0;
            r_trig        <= 1'b0;
            r_busy        <= 1'b0;
            r_grant_valid <= 1'b0;
        end else if (!enable) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_trig        <= 1'b0;
            r_busy        <= 1'b0;
            r_grant_valid <= 1'b0;
        end else begin
            r_grant_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_any) begin
                        r_grant_valid <= 1'b1;
                        r_grant_id    <= w_gnt_id;
                        r_last_id     <= w_gnt_id;
                        r_width_m1    <= w_width_m1;
                        r_holdoff     <= holdoff_cycles;
                        r_cnt         <= delay_cycles;
                        r_busy        <= 1'b1;
                        r_state       <= DELAY;
                    end
                end
                DELAY: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= r_width_m1;
                        r_trig  <= 1'b1;
                        r_state <= ACTIVE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ACTIVE: begin
                    if (r_cnt == '0) begin
                        r_trig <= 1'b0;
                        if (r_holdoff == '0) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt   <= r_holdoff;
                            r_state <= HOLDOFF;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                HOLDOFF: begin
                    if (r_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign trig_out    = r_trig;
    assign busy        = r_busy;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;

`ifdef TRIG_SEQ_OVERRUN_EN
    localparam int OS_W = OVERRUN_W + 1;

    logic [NUM_SRC-1:0]   w_lost;
    logic [OS_W-1:0]      w_over_sum;
    logic [OVERRUN_W-1:0] r_overrun;

    // The carry bit of the sum flags saturation.
    always_comb begin
        w_lost     = w_edge & r_pending & ~w_clear;
        w_over_sum = {1'b0, r_overrun};
        for (int i = 0; i < NUM_SRC; i++) begin
            w_over_sum = w_over_sum + OS_W'(w_lost[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= '0;
        end else begin
            r_overrun <= w_over_sum[OVERRUN_W] ? '1 : w_over_sum[OVERRUN_W-1:0];
        end
    end

    assign overrun_cnt = r_overrun;
`endif

endmodule

// File: tb/tb_trigger_sequencer.sv
// Scoreboard bench for trigger_sequencer: a cycle-level reference model queues expected
// grants and pulses, and a negedge monitor compares them against the DUT.
module tb_trigger_sequencer;

    localparam int NUM_SRC = 3;
    localparam int CNT_W   = 16;
    localparam int ID_W    = $clog2(NUM_SRC);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                enable = 1'b0;
    logic [NUM_SRC-1:0]  src_req = '0;
    logic [NUM_SRC-1:0]  src_mask = '1;
    logic [CNT_W-1:0]    delay_cycles = '0;
    logic [CNT_W-1:0]    width_cycles = '0;
    logic [CNT_W-1:0]    holdoff_cycles = '0;
    logic                trig_out;
    logic                busy;
    logic                grant_valid;
    logic [ID_W-1:0]     grant_id;
`ifdef TRIG_SEQ_OVERRUN_EN
    logic [7:0]          overrun_cnt;
`endif

    always #5 clk = ~clk;

    trigger_sequencer #(
        .NUM_SRC        (NUM_SRC),
        .CNT_W          (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .src_req        (src_req),
        .src_mask       (src_mask),
        .delay_cycles   (delay_cycles),
        .width_cycles   (width_cycles),
        .holdoff_cycles (holdoff_cycles),
        .trig_out       (trig_out),
        .busy           (busy),
        .grant_valid    (grant_valid),
        .grant_id       (grant_id)
`ifdef TRIG_SEQ_OVERRUN_EN
        ,
        .overrun_cnt    (overrun_cnt)
`endif
    );

    typedef struct {
        int len;
        int rise;
    } pulse_t;

    int     checks = 0;
    int     errors = 0;
    int     grantQ[$];
    pulse_t pulseQ[$];

    bit [NUM_SRC-1:0] mPrev, mPend, mEdges, mClr;
    bit               mInflight, mTrig, mTrigNow, mBusy;
    int               mLast, mT, mD, mW, mH, mL, mLen, mOver, mG;

    // Reference model: a sequence is just "L busy cycles after the grant", with the
    // pulse occupying cycles D+1 .. D+W of that window.
    always @(posedge clk) begin
        if (!rst_n) begin
            mPrev = '0; mPend = '0; mInflight = 0; mTrig = 0; mBusy = 0;
            mLast = NUM_SRC - 1; mT = 0; mD = 0; mW = 1; mH = 0; mL = 0; mLen = 0; mOver = 0;
        end else begin
            mEdges = src_req & ~mPrev & src_mask & {NUM_SRC{enable}};
            mPrev  = src_req;
            mClr   = '0;
            mG     = -1;
            if (!enable) begin
                if (mTrig) pulseQ.push_back('{mLen, mD + 1});
                mPend = '0; mInflight = 0; mTrig = 0; mLen = 0;
            end else begin
                if (mInflight) begin
                    mT++;
                    if (mT == mL) mInflight = 0;
                end else if (mPend != 0) begin
                    for (int k = 1; k <= NUM_SRC; k++) begin
                        if (mG < 0 && mPend[(mLast + k) % NUM_SRC]) mG = (mLast + k) % NUM_SRC;
                    end
                    mLast = mG;
                    mClr[mG] = 1'b1;
                    grantQ.push_back(mG);
                    mD = int'(delay_cycles);
                    mW = (width_cycles == 0) ? 1 : int'(width_cycles);
                    mH = int'(holdoff_cycles);
                    mL = mD + 1 + mW + ((mH == 0) ? 0 : mH + 1);
                    mT = 0;
                    mInflight = 1;
                end
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (mEdges[i] && mPend[i] && !mClr[i] && mOver < 255) mOver++;
                end
                mPend = (mPend & ~mClr) | mEdges;
                mTrigNow = mInflight && (mT >= mD + 1) && (mT <= mD + mW);
                if (mTrigNow) begin
                    mLen++;
                end else if (mTrig) begin
                    pulseQ.push_back('{mLen, mD + 1});
                    mLen = 0;
                end
                mTrig = mTrigNow;
            end
            mBusy = mInflight;
        end
    end

    int     sinceGrant = 0;
    int     obsLen = 0;
    int     obsRise = 0;
    bit     prevTrig = 0;
    int     expId;
    pulse_t expP;

    // Monitor: pops an expectation whenever the DUT grants or finishes a pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (grant_valid) begin
                checks++;
                if (grantQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL grant_unexpected got id=%0d expected no grant", grant_id);
                end else begin
                    expId = grantQ.pop_front();
                    if (int'(grant_id) != expId) begin
                        errors++;
                        $display("[TB] FAIL grant_id got %0d expected %0d", grant_id, expId);
                    end
                end
                sinceGrant = 0;
            end else begin
                sinceGrant++;
            end
            if (trig_out) begin
                if (!prevTrig) begin
                    obsRise = sinceGrant;
                    obsLen  = 1;
                end else begin
                    obsLen++;
                end
            end else if (prevTrig) begin
                checks++;
                if (pulseQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL pulse_unexpected got len=%0d expected no pulse", obsLen);
                end else begin
                    expP = pulseQ.pop_front();
                    if (obsLen != expP.len || obsRise != expP.rise) begin
                        errors++;
                        $display("[TB] FAIL pulse_shape got len=%0d rise=%0d expected len=%0d rise=%0d",
                                 obsLen, obsRise, expP.len, expP.rise);
                    end
                end
            end
            prevTrig = trig_out;
            checks++;
            if (busy !== mBusy) begin
                errors++;
                $display("[TB] FAIL busy got %0b expected %0b", busy, mBusy);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic setConfig(input int d, input int w, input int h);
        delay_cycles   = CNT_W'(d);
        width_cycles   = CNT_W'(w);
        holdoff_cycles = CNT_W'(h);
    endtask

    task automatic applyStimulus(input logic [NUM_SRC-1:0] req, input int cycles);
        src_req = req;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_trig_out", int'(trig_out), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_grant_valid", int'(grant_valid), 0);
        checkOutput("reset_grant_id", int'(grant_id), 0);
`ifdef TRIG_SEQ_OVERRUN_EN
        checkOutput("reset_overrun", int'(overrun_cnt), 0);
`endif
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        enable = 1'b1;

        // single request
        setConfig(0, 3, 0);
        applyStimulus(3'b001, 10);
        applyStimulus(3'b000, 2);

        // simultaneous requests served in round-robin order
        setConfig(0, 2, 1);
        applyStimulus(3'b111, 20);
        applyStimulus(3'b000, 2);

        // config changed mid-sequence must not affect the pulse
        setConfig(5, 4, 0);
        applyStimulus(3'b010, 3);
        width_cycles = CNT_W'(10);
        applyStimulus(3'b010, 15);
        applyStimulus(3'b000, 2);

        // abort during ACTIVE with src1 pending; no grant after re-enable
        setConfig(2, 6, 0);
        applyStimulus(3'b001, 1);
        applyStimulus(3'b011, 5);
        enable = 1'b0;
        applyStimulus(3'b011, 2);
        enable = 1'b1;
        applyStimulus(3'b011, 20);
        applyStimulus(3'b000, 3);

        // masked source ignored, width 0 gives one-cycle pulse
        setConfig(0, 0, 0);
        src_mask = 3'b011;
        applyStimulus(3'b100, 5);
        applyStimulus(3'b110, 5);
        applyStimulus(3'b000, 3);
        src_mask = 3'b111;

        // overrun: served, pending, dropped
        setConfig(100, 1, 0);
        applyStimulus(3'b001, 1);
        applyStimulus(3'b000, 1);
        applyStimulus(3'b001, 1);
        applyStimulus(3'b000, 1);
        applyStimulus(3'b001, 230);
        applyStimulus(3'b000, 2);
`ifdef TRIG_SEQ_OVERRUN_EN
        checkOutput("overrun_single", int'(overrun_cnt), mOver);
`endif

        // overrun saturation
        setConfig(3000, 1, 0);
        for (int n = 0; n < 301; n++) begin
            applyStimulus(3'b001, 1);
            applyStimulus(3'b000, 1);
        end
`ifdef TRIG_SEQ_OVERRUN_EN
        checkOutput("overrun_saturated", int'(overrun_cnt), 255);
`endif
        enable = 1'b0;
        applyStimulus(3'b000, 2);
        enable = 1'b1;
        applyStimulus(3'b000, 2);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) src_req = src_req ^ NUM_SRC'($urandom);
            if ($urandom_range(0, 40) == 0) src_mask = NUM_SRC'($urandom);
            if ($urandom_range(0, 20) == 0)
                setConfig(int'($urandom_range(0, 6)), int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
            if ($urandom_range(0, 150) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 2) == 0) enable = 1'b1;
            @(posedge clk);
            #1;
        end

        enable   = 1'b1;
        src_mask = 3'b111;
        applyStimulus(3'b000, 150);
        checkOutput("grant_queue_drained", grantQ.size(), 0);
        checkOutput("pulse_queue_drained", pulseQ.size(), 0);
`ifdef TRIG_SEQ_OVERRUN_EN
        checkOutput("overrun_final", int'(overrun_cnt), mOver);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trigger_sequencer.md
# trigger_sequencer

Schedules camera trigger pulses for the camera controller. Several trigger sources share one trigger output: software, external pin and periodic timer. Each source's rising edge is captured as a pending request. A round-robin arbiter grants one request at a time. The granted request produces a programmable delay, a stretched trigger pulse and a holdoff window before the next grant. The block sits between the trigger sources and the sensor trigger/strobe pads, and owns all trigger timing.

## Interface
- `NUM_SRC`, default 3: number of trigger sources (2..8).
- `CNT_W`, default 16: width of the delay, width and holdoff counters.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: sequencer enable. Low aborts any sequence and clears all pending requests.
- `src_req` in NUM_SRC: level trigger inputs, already synchronous to `clk`. Only rising edges are used.
- `src_mask` in NUM_SRC: 1 = source allowed. Edges from masked sources are ignored.
- `delay_cycles` in CNT_W: cycles from grant to the pulse.
- `width_cycles` in CNT_W: pulse width in cycles. 0 is treated as 1.
- `holdoff_cycles` in CNT_W: dead time after the pulse.
- `trig_out` out 1: stretched trigger pulse, registered.
- `busy` out 1: high in any state except IDLE.
- `grant_valid` out 1: one-cycle pulse on each grant.
- `grant_id` out $clog2(NUM_SRC): source granted. Held until the next grant.
- `overrun_cnt` out 8: only with TRIG_SEQ_OVERRUN_EN. Saturating count of edges lost because that source was already pending.

## Operation
- **Edge detect.** `src_req_d1` is registered. `edge[i] = src_req[i] & ~src_req_d1[i] & src_mask[i] & enable`.
- **Pending register.** Bit i is set on `edge[i]` and cleared when source i is granted. If set and clear hit the same cycle, set wins.
- **Arbitration.** Round-robin pointer `last_id`. The search starts at `last_id+1` and wraps modulo NUM_SRC. Reset value of `last_id` is NUM_SRC-1, so source 0 wins the first grant.
- **FSM states:** IDLE, DELAY, ACTIVE, HOLDOFF.
  - IDLE: if `enable` and `pending != 0`, grant, latch `delay`/`width`/`holdoff`, set `cnt = delay`, go to DELAY.
  - DELAY: if `cnt == 0`, set `cnt = max(width,1) - 1` and go to ACTIVE; else `cnt--`.
  - ACTIVE (`trig_out = 1`): if `cnt == 0`, go to HOLDOFF with `cnt = holdoff`, or straight to IDLE if `holdoff == 0`; else `cnt--`.
  - HOLDOFF: if `cnt == 0`, go to IDLE; else `cnt--`. A holdoff of H yields H+1 HOLDOFF cycles.
- **Config latching.** Parameters are latched at grant. Changing the inputs mid-sequence has no effect on the sequence in flight.
- **Abort.** `enable` low in any state: next edge goes to IDLE, `trig_out` = 0, `pending` = 0. `last_id` and `grant_id` are kept.
- **Requests while busy.** Edges arriving while busy are latched in `pending` and served after IDLE is re-entered. At most one request per source is pending.

## Timing
- Reset values: `trig_out` = 0, `busy` = 0, `grant_valid` = 0, `grant_id` = 0, `overrun_cnt` = 0, FSM = IDLE, `pending` = 0, counters = 0.
- Source edge sampled at clock edge E0 → pending set at E0 → grant at E1 (`grant_valid` and `busy` high from E1 for one cycle) → `trig_out` rises at E2+delay and stays high exactly `max(width,1)` cycles.
- Back-to-back requests: the next grant occurs at the first IDLE cycle. This gives a minimum gap of holdoff+2 cycles from `trig_out` falling to the next grant pulse (holdoff+1 HOLDOFF cycles plus one IDLE cycle), or 1 cycle when `holdoff == 0`.
- Counters never wrap. The maximum delay of 2^CNT_W-1 gives exactly 2^CNT_W DELAY cycles.

## Configuration
- `TRIG_SEQ_OVERRUN_EN` defined: `overrun_cnt` port present. It increments, saturating at 255, when `edge[i]` arrives while `pending[i]` is already set and not being cleared that cycle.
- `TRIG_SEQ_OVERRUN_EN` undefined: port and logic absent; overrun edges are silently dropped.

## Structure
- Package `trig_seq_pkg`:
  - state enum `trig_seq_state_e` (IDLE, DELAY, ACTIVE, HOLDOFF);
  - `OVERRUN_W = 8`;
  - function `max1(width)`.
- Sub-module `rr_arbiter`, parameterized NUM_SRC:
  - inputs: `req`, `last_id`;
  - outputs: `gnt_onehot`, `gnt_id`, `gnt_any`;
  - combinational only.

## Test plan
1. Single request, delay=0, width=3, holdoff=0, src0 rises at E0 → `grant_valid`/`grant_id=0` at E1; `trig_out` high at E2..E4; `busy` low at E5.
2. Round robin, src0/1/2 rise on the same cycle, width=2, holdoff=1 → grants in order 0, 1, 2, each separated per the timing rules, with no lost pulse.
3. Latching, delay=5, width=4; change width to 10 during DELAY → `trig_out` high exactly 4 cycles, rising 7 cycles after the input edge.
4. Abort, `enable` dropped in the middle of ACTIVE with src1 pending → `trig_out` low next cycle, `pending` cleared; after re-enable, no grant until a new edge.
5. Masking, width=0, src2 masked → a src2 edge causes no grant; a src1 edge yields a 1-cycle pulse.
6. Overrun (`TRIG_SEQ_OVERRUN_EN` defined), three src0 edges during a long delay=100 → `overrun_cnt = 1` (one served, one pending, one dropped); 300 overrun edges saturate the counter at 255.
